// File: rtl/char_action_fsm_if.sv
// Frame-tick, button and action-state signals exchanged between the
// character action FSM and its driver/consumer.
interface char_action_fsm_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_attack;
  logic [3:0] state;
  logic       move_flag;
  logic       attack_hit;
  logic       busy;

  modport master (
    output frame_tick, btn_left, btn_right, btn_attack,
    input  state, move_flag, attack_hit, busy
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_attack,
    output state, move_flag, attack_hit, busy
  );
endinterface

// File: rtl/char_action_fsm.sv
// Character action FSM: idle/move selection and two three-phase attacks,
// advanced only on frame ticks, with registered status outputs.
module char_action_fsm #(
  parameter int START_FRAMES        = 5,
  parameter int ACTIVE_FRAMES       = 2,
  parameter int RECOVERY_FRAMES     = 16,
  parameter int DIR_START_FRAMES    = 4,
  parameter int DIR_ACTIVE_FRAMES   = 3,
  parameter int DIR_RECOVERY_FRAMES = 15
) (
  input logic              clk,
  input logic              rst,
  char_action_fsm_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE                = 4'd0,
    LEFT                = 4'd1,
    RIGHT               = 4'd2,
    ATTACK_START        = 4'd3,
    ATTACK_ACTIVE       = 4'd4,
    ATTACK_RECOVERY     = 4'd5,
    ATTACK_DIR_START    = 4'd6,
    ATTACK_DIR_ACTIVE   = 4'd7,
    ATTACK_DIR_RECOVERY = 4'd8
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [4:0] cnt_r;
  logic [4:0] cnt_nxt_s;
  logic       attack_prev_r;
  logic       attack_prev_nxt_s;
  logic       attack_edge_s;
  logic       move_flag_r;
  logic       attack_hit_r;
  logic       busy_r;

  // Counter preload for a phase: dwell minus one, so the exit tick sees zero.
  function automatic logic [4:0] phase_len(input state_t st);
    logic [4:0] len;
    case (st)
      ATTACK_START:        len = 5'(START_FRAMES - 1);
      ATTACK_ACTIVE:       len = 5'(ACTIVE_FRAMES - 1);
      ATTACK_RECOVERY:     len = 5'(RECOVERY_FRAMES - 1);
      ATTACK_DIR_START:    len = 5'(DIR_START_FRAMES - 1);
      ATTACK_DIR_ACTIVE:   len = 5'(DIR_ACTIVE_FRAMES - 1);
      ATTACK_DIR_RECOVERY: len = 5'(DIR_RECOVERY_FRAMES - 1);
      default:             len = 5'd0;
    endcase
    return len;
  endfunction

  function automatic state_t next_phase(input state_t st);
    state_t nxt;
    case (st)
      ATTACK_START:      nxt = ATTACK_ACTIVE;
      ATTACK_ACTIVE:     nxt = ATTACK_RECOVERY;
      ATTACK_DIR_START:  nxt = ATTACK_DIR_ACTIVE;
      ATTACK_DIR_ACTIVE: nxt = ATTACK_DIR_RECOVERY;
      default:           nxt = IDLE;
    endcase
    return nxt;
  endfunction

  function automatic logic is_attack(input state_t st);
    return (st == ATTACK_START)     || (st == ATTACK_ACTIVE)     ||
           (st == ATTACK_RECOVERY)  || (st == ATTACK_DIR_START)  ||
           (st == ATTACK_DIR_ACTIVE)|| (st == ATTACK_DIR_RECOVERY);
  endfunction

  assign attack_edge_s = bus.btn_attack & ~attack_prev_r;

  // Next-state and counter logic; nothing moves without a frame tick.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    attack_prev_nxt_s = attack_prev_r;
    if (bus.frame_tick) begin
      attack_prev_nxt_s = bus.btn_attack;
      case (state_r)
        IDLE, LEFT, RIGHT: begin
          if (attack_edge_s && (bus.btn_left ^ bus.btn_right)) begin
            state_nxt_s = ATTACK_DIR_START;
          end else if (attack_edge_s) begin
            state_nxt_s = ATTACK_START;
          end else if (bus.btn_left && !bus.btn_right) begin
            state_nxt_s = LEFT;
          end else if (bus.btn_right && !bus.btn_left) begin
            state_nxt_s = RIGHT;
          end else begin
            state_nxt_s = IDLE;
          end
          cnt_nxt_s = phase_len(state_nxt_s);
        end
        ATTACK_START, ATTACK_ACTIVE, ATTACK_RECOVERY,
        ATTACK_DIR_START, ATTACK_DIR_ACTIVE, ATTACK_DIR_RECOVERY: begin
          if (cnt_r != 5'd0) begin
            cnt_nxt_s = cnt_r - 5'd1;
          end else begin
            state_nxt_s = next_phase(state_r);
            cnt_nxt_s   = phase_len(state_nxt_s);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 5'd0;
        end
      endcase
    end else begin
      state_nxt_s       = state_r;
      cnt_nxt_s         = cnt_r;
      attack_prev_nxt_s = attack_prev_r;
    end
  end

  // State, counter and status registers; status is derived from the next
  // state so it lines up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 5'd0;
      attack_prev_r <= 1'b0;
      move_flag_r   <= 1'b0;
      attack_hit_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      attack_prev_r <= attack_prev_nxt_s;
      move_flag_r   <= bus.frame_tick &&
                       ((state_nxt_s == LEFT) || (state_nxt_s == RIGHT));
      attack_hit_r  <= (state_nxt_s == ATTACK_ACTIVE) ||
                       (state_nxt_s == ATTACK_DIR_ACTIVE);
      busy_r        <= is_attack(state_nxt_s);
    end
  end

  assign bus.state      = state_r;
  assign bus.move_flag  = move_flag_r;
  assign bus.attack_hit = attack_hit_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_char_action_fsm.sv
// Directed testbench for char_action_fsm with default frame counts.
module tb_char_action_fsm;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   mf_cnt;
  int   busy_ticks;

  char_action_fsm_if bus();

  char_action_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count clk cycles in which move_flag is high.
  always @(negedge clk) begin
    if (bus.move_flag === 1'b1) mf_cnt = mf_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame tick, then an idle clk; outputs sampled at the negedge after
  // the tick's posedge.
  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic run_phase(input string tag, input int exp_st, input int n,
                           input logic exp_hit);
    for (int i = 0; i < n; i++) begin
      tick();
      check_eq({tag, "_state"}, 32'(bus.state), 32'(exp_st));
      check_eq({tag, "_hit"}, 32'(bus.attack_hit), 32'(exp_hit));
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (bus.busy === 1'b1) busy_ticks = busy_ticks + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mf_cnt = 0;
    busy_ticks = 0;
    rst = 1'b1;
    bus.frame_tick = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_attack = 1'b0;
    do_reset();
    check_eq("rst_state", 32'(bus.state), 32'd0);
    check_eq("rst_move", 32'(bus.move_flag), 32'd0);
    check_eq("rst_hit", 32'(bus.attack_hit), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);

    // No tick: buttons alone change nothing.
    bus.btn_right = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_tick_state", 32'(bus.state), 32'd0);

    // Right held for three ticks: three one-clk move pulses.
    mf_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("right_state", 32'(bus.state), 32'd2);
      check_eq("right_move", 32'(bus.move_flag), 32'd1);
    end
    @(negedge clk);
    check_eq("right_move_low", 32'(bus.move_flag), 32'd0);
    bus.btn_right = 1'b0;
    tick();
    check_eq("right_release", 32'(bus.state), 32'd0);
    check_eq("right_pulses", 32'(mf_cnt), 32'd3);

    // Neutral attack with attack held throughout: 5/2/16 then IDLE.
    bus.btn_attack = 1'b1;
    busy_ticks = 0;
    run_phase("n_start", 3, 5, 1'b0);
    run_phase("n_active", 4, 2, 1'b1);
    run_phase("n_recov", 5, 16, 1'b0);
    check_eq("n_busy_ticks", 32'(busy_ticks), 32'd23);
    tick();
    check_eq("n_idle", 32'(bus.state), 32'd0);
    check_eq("n_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    check_eq("held_no_retrig", 32'(bus.state), 32'd0);
    bus.btn_attack = 1'b0;
    tick();
    check_eq("release_idle", 32'(bus.state), 32'd0);
    bus.btn_attack = 1'b1;
    tick();
    check_eq("repress_start", 32'(bus.state), 32'd3);
    bus.btn_attack = 1'b0;
    repeat (4) tick();
    tick();
    check_eq("pre_rst_active", 32'(bus.state), 32'd4);
    check_eq("pre_rst_hit", 32'(bus.attack_hit), 32'd1);

    // Reset wins over a coincident frame tick mid-attack.
    @(negedge clk);
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    check_eq("midrst_state", 32'(bus.state), 32'd0);
    check_eq("midrst_hit", 32'(bus.attack_hit), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);

    // Directional attack: left plus attack edge, 4/3/15, no move pulses.
    mf_cnt = 0;
    busy_ticks = 0;
    bus.btn_left = 1'b1;
    bus.btn_attack = 1'b1;
    run_phase("d_start", 6, 4, 1'b0);
    run_phase("d_active", 7, 3, 1'b1);
    run_phase("d_recov", 8, 15, 1'b0);
    check_eq("d_busy_ticks", 32'(busy_ticks), 32'd22);
    tick();
    check_eq("d_exit_idle", 32'(bus.state), 32'd0);
    check_eq("d_no_move", 32'(mf_cnt), 32'd0);
    tick();
    check_eq("d_then_left", 32'(bus.state), 32'd1);
    check_eq("d_then_move", 32'(bus.move_flag), 32'd1);

    // Both directions: idle, and an attack edge gives the neutral attack.
    bus.btn_attack = 1'b0;
    bus.btn_right = 1'b1;
    tick();
    check_eq("both_state", 32'(bus.state), 32'd0);
    check_eq("both_move", 32'(bus.move_flag), 32'd0);
    bus.btn_attack = 1'b1;
    tick();
    check_eq("both_attack", 32'(bus.state), 32'd3);
    check_eq("both_busy", 32'(bus.busy), 32'd1);

    do_reset();
    check_eq("final_rst", 32'(bus.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/char_action_fsm.md
CHAR_ACTION_FSM -- requirements
Module: char_action_fsm

Interface
REQ-001 SHALL have parameter START_FRAMES, default 5: frame ticks spent in neutral attack startup.
REQ-002 SHALL have parameter ACTIVE_FRAMES, default 2: frame ticks spent in neutral attack active.
REQ-003 SHALL have parameter RECOVERY_FRAMES, default 16: frame ticks spent in neutral attack recovery.
REQ-004 SHALL have parameter DIR_START_FRAMES, default 4: frame ticks spent in directional attack startup.
REQ-005 SHALL have parameter DIR_ACTIVE_FRAMES, default 3: frame ticks spent in directional attack active.
REQ-006 SHALL have parameter DIR_RECOVERY_FRAMES, default 15: frame ticks spent in directional attack recovery.
REQ-007 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-009 SHALL have port frame_tick, input, 1: one-clk pulse per video frame; the only event that advances the FSM.
REQ-010 SHALL have port btn_left, input, 1: left button level, already synchronized, active-high.
REQ-011 SHALL have port btn_right, input, 1: right button level, already synchronized, active-high.
REQ-012 SHALL have port btn_attack, input, 1: attack button level, already synchronized, active-high.
REQ-013 SHALL have port state, output, 4: current action code, consumed by the position handler.
REQ-014 SHALL have port move_flag, output, 1: one-clk movement strobe, consumed as the position handler's button_flag.
REQ-015 SHALL have port attack_hit, output, 1: high while state is ATTACK_ACTIVE or ATTACK_DIR_ACTIVE.
REQ-016 SHALL have port busy, output, 1: high while state is any of the six attack codes.

Function
REQ-017 SHALL encode state as: IDLE 0000, LEFT 0001, RIGHT 0010, ATTACK_START 0011, ATTACK_ACTIVE 0100, ATTACK_RECOVERY 0101, ATTACK_DIR_START 0110, ATTACK_DIR_ACTIVE 0111, ATTACK_DIR_RECOVERY 1000; codes 1001-1111 SHALL never be output.
REQ-018 SHALL hold state, the phase counter, and attack_prev unchanged in every cycle where frame_tick=0.
REQ-019 SHALL define attack_edge = btn_attack & ~attack_prev, and SHALL load attack_prev <= btn_attack on every frame_tick, in every state.
REQ-020 SHALL, on frame_tick in IDLE/LEFT/RIGHT, select the next state by priority: attack_edge & (btn_left ^ btn_right) -> ATTACK_DIR_START; attack_edge -> ATTACK_START; btn_left & ~btn_right -> LEFT; btn_right & ~btn_left -> RIGHT; otherwise -> IDLE.
REQ-021 SHALL, on entry to each attack phase, load a 5-bit phase counter with that phase's frame count minus 1.
REQ-022 SHALL, on frame_tick in an attack phase with counter != 0, decrement the counter and remain in the phase.
REQ-023 SHALL, on frame_tick in an attack phase with counter = 0, advance START->ACTIVE->RECOVERY within the same attack type, and RECOVERY->IDLE.
REQ-024 SHALL give each attack phase a dwell of exactly its parameter value in frame ticks.
REQ-025 SHALL ignore button inputs during attack phases, except for the attack_prev update; no input is buffered.
REQ-026 SHALL always exit RECOVERY to IDLE, so that movement or a new attack begins no earlier than the next frame_tick.
REQ-027 SHALL set move_flag=1 for exactly the clk cycle in which the state register newly holds a value latched by a frame_tick whose next state is LEFT or RIGHT, and move_flag=0 in all other cycles.
REQ-028 SHALL drive attack_hit and busy as registered outputs, cycle-aligned with state.
REQ-029 SHALL accept frame-count parameters only in the range 1-31; 0 or values >31 are illegal and need not be handled.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set state=IDLE, counter=0, attack_prev=0, move_flag=0, attack_hit=0, busy=0, regardless of frame_tick or the current state, including mid-attack.
REQ-031 SHALL give rst priority over frame_tick in the same cycle.

Verification
REQ-032 SHALL be verified by: hold btn_right=1 for 3 frame_ticks from IDLE -> state=0010 after the first tick; move_flag pulses exactly 3 times, one clk each.
REQ-033 SHALL be verified by: btn_attack rises from IDLE with defaults -> states 0011 for 5 ticks, 0100 for 2 ticks (attack_hit=1), 0101 for 16 ticks, then 0000; busy=1 for exactly 23 ticks.
REQ-034 SHALL be verified by: btn_left=1 and btn_attack rising at the same tick -> sequence 0110/0111/1000 with dwell 4/3/15 ticks; move_flag stays 0 throughout.
REQ-035 SHALL be verified by: btn_attack held continuously through an entire attack -> returns to IDLE, no re-trigger; btn_attack released then pressed again -> new ATTACK_START.
REQ-036 SHALL be verified by: btn_left=btn_right=1 -> state=IDLE and move_flag=0; btn_left=btn_right=1 with attack_edge -> ATTACK_START, not the directional attack.
REQ-037 SHALL be verified by: rst asserted during ATTACK_ACTIVE together with frame_tick -> the next cycle shows state=0000, attack_hit=0, busy=0.
